// File: rtl/avmm_sdram_burst_reader_if.sv
// Avalon-MM read-only bus bundle between a burst read master and an SDRAM port.
interface avmm_sdram_burst_reader_if #(
    parameter int SDRAM_DATA_W = 128,
    parameter int ADDR_W       = 32,
    parameter int BURST_W      = 8
);
    logic [SDRAM_DATA_W-1:0] readdata;
    logic                    readdatavalid;
    logic                    waitrequest;
    logic                    read;
    logic [ADDR_W-1:0]       address;
    logic [BURST_W-1:0]      burstcount;

    modport master (
        input  readdata, readdatavalid, waitrequest,
        output read, address, burstcount
    );

    modport slave (
        output readdata, readdatavalid, waitrequest,
        input  read, address, burstcount
    );
endinterface

// File: rtl/avmm_sdram_burst_reader.sv
// Avalon-MM burst read master: fetches read_cnt beats, one burst outstanding at a time.
// Optional macro AVMM_RD_REG_OUT_EN registers read_data/read_valid (1-cycle latency).
module avmm_sdram_burst_reader #(
    parameter int SDRAM_DATA_W = 128,
    parameter int ADDR_W       = 32,
    parameter int BURST_W      = 8,
    parameter int MAX_BURST    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    avmm_sdram_burst_reader_if.master avm,
    input  logic                    read_start,
    input  logic [31:0]             read_addr,
    input  logic [10:0]             read_cnt,
    output logic                    read_valid,
    output logic [SDRAM_DATA_W-1:0] read_data,
    output logic                    read_done
);
    localparam int BYTES = SDRAM_DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;
    logic [ADDR_W-1:0]  cur_addr;
    logic [10:0]        remaining;
    logic [BURST_W-1:0] beats_left;
    logic               zero_done;

    logic [31:0]        aligned_addr;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W-1:0]  next_addr;
    logic [10:0]        rem_next;
    logic               beat;

    function automatic logic [BURST_W-1:0] clamp_burst(input logic [10:0] r);
        if (int'(r) >= MAX_BURST)
            return BURST_W'(MAX_BURST);
        else
            return BURST_W'(r);
    endfunction

    assign aligned_addr = read_addr & ~32'(BYTES - 1);
    assign start_addr   = ADDR_W'(aligned_addr);
    assign next_addr    = cur_addr + (ADDR_W'(avm.burstcount) << OFF_W);
    assign rem_next     = remaining - 11'd1;
    assign beat         = avm.readdatavalid && (state == DATA);

    // Command outputs are registered; address/burstcount stay put while stalled in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cur_addr       <= '0;
            remaining      <= '0;
            beats_left     <= '0;
            zero_done      <= 1'b0;
            avm.read       <= 1'b0;
            avm.address    <= '0;
            avm.burstcount <= '0;
        end else begin
            zero_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_start) begin
                        if (read_cnt != 11'd0) begin
                            cur_addr       <= start_addr;
                            remaining      <= read_cnt;
                            avm.read       <= 1'b1;
                            avm.address    <= start_addr;
                            avm.burstcount <= clamp_burst(read_cnt);
                            state          <= REQ;
                        end else begin
                            zero_done <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (!avm.waitrequest) begin
                        avm.read   <= 1'b0;
                        beats_left <= avm.burstcount;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (avm.readdatavalid) begin
                        remaining  <= rem_next;
                        beats_left <= beats_left - BURST_W'(1);
                        if (beats_left == BURST_W'(1)) begin
                            cur_addr <= next_addr;
                            if (rem_next != 11'd0) begin
                                avm.read       <= 1'b1;
                                avm.address    <= next_addr;
                                avm.burstcount <= clamp_burst(rem_next);
                                state          <= REQ;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AVMM_RD_REG_OUT_EN
    logic done_dly;

    // The done pulse is delayed one cycle so it trails the registered final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_valid <= 1'b0;
            read_data  <= '0;
            done_dly   <= 1'b0;
        end else begin
            read_valid <= beat;
            read_data  <= avm.readdata;
            done_dly   <= (state == DONE);
        end
    end

    assign read_done = done_dly | zero_done;
`else
    assign read_valid = beat;
    assign read_data  = avm.readdata;
    assign read_done  = (state == DONE) | zero_done;
`endif
endmodule

// File: tb/tb_avmm_sdram_burst_reader.sv
// Self-checking bench: table-driven transfers against an Avalon slave model plus a beat scoreboard.
module tb_avmm_sdram_burst_reader;
    localparam int MAXB = 64;

    typedef struct {
        logic [31:0] addr;
        logic [10:0] cnt;
        int          stall;
        bit          gap;
        int          exp_bursts;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  bc;
    } cmd_t;

    logic          clk;
    logic          rst_n;
    logic          read_start;
    logic [31:0]   read_addr;
    logic [10:0]   read_cnt;
    logic          read_valid;
    logic [127:0]  read_data;
    logic          read_done;

    logic          slave_dv, noise_dv, slave_wr;
    logic [127:0]  slave_rd;

    int            pass_count = 0;
    int            total_count = 0;
    int            done_count = 0;
    int            cmd_count = 0;
    int            read_seen = 0;
    int            stall_cfg = 0;
    bit            gap_en = 1'b0;

    logic [127:0]  exp_data[$];
    cmd_t          exp_cmd[$];
    vec_t          vecs[8];

    avmm_sdram_burst_reader_if #(.SDRAM_DATA_W(128), .ADDR_W(32), .BURST_W(8)) bus ();

    assign bus.readdatavalid = slave_dv | noise_dv;
    assign bus.readdata      = slave_rd;
    assign bus.waitrequest   = slave_wr;

    avmm_sdram_burst_reader #(
        .SDRAM_DATA_W(128), .ADDR_W(32), .BURST_W(8), .MAX_BURST(MAXB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .avm        (bus.master),
        .read_start (read_start),
        .read_addr  (read_addr),
        .read_cnt   (read_cnt),
        .read_valid (read_valid),
        .read_data  (read_data),
        .read_done  (read_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] beat_data(input logic [31:0] a);
        return {~a, a ^ 32'hA5A5_5A5A, a + 32'h0001_2345, a};
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Slave model: stalls each command stall_cfg cycles, then returns beats from a synthetic memory.
    int          beats_pend = 0;
    int          stall_left = 0;
    bit          in_cmd = 1'b0;
    logic [31:0] beat_addr, cap_addr;
    logic [7:0]  cap_bc;
    cmd_t        cmd_exp;

    always begin
        @(posedge clk);
        #1;
        slave_dv = 1'b0;
        slave_rd = '0;
        if (!rst_n) begin
            beats_pend = 0;
            in_cmd     = 1'b0;
            slave_wr   = 1'b0;
        end else if (beats_pend > 0) begin
            if (!gap_en || $urandom_range(0, 3) != 0) begin
                slave_dv   = 1'b1;
                slave_rd   = beat_data(beat_addr);
                beat_addr  = beat_addr + 32'd16;
                beats_pend = beats_pend - 1;
            end
        end else if (bus.read) begin
            if (!in_cmd) begin
                in_cmd     = 1'b1;
                cap_addr   = bus.address;
                cap_bc     = bus.burstcount;
                stall_left = stall_cfg;
            end else begin
                check_output("hold_address", 128'(bus.address), 128'(cap_addr));
                check_output("hold_burstcount", 128'(bus.burstcount), 128'(cap_bc));
            end
            if (stall_left > 0) begin
                slave_wr   = 1'b1;
                stall_left = stall_left - 1;
            end else begin
                slave_wr   = 1'b0;
                in_cmd     = 1'b0;
                cmd_count++;
                if (exp_cmd.size() == 0) begin
                    check_output("extra_cmd", 128'(bus.read), 128'(0));
                end else begin
                    cmd_exp = exp_cmd.pop_front();
                    check_output("cmd_address", 128'(bus.address), 128'(cmd_exp.addr));
                    check_output("cmd_burstcount", 128'(bus.burstcount), 128'(cmd_exp.bc));
                end
                beats_pend = int'(bus.burstcount);
                beat_addr  = bus.address;
            end
        end else begin
            slave_wr = 1'b0;
        end
    end

    // Output monitor: scoreboard pop on every beat, done must not precede the final beat.
    logic [127:0] mon_exp;
    always @(negedge clk) begin
        if (bus.read) read_seen++;
        if (read_valid) begin
            if (exp_data.size() == 0) begin
                check_output("extra_beat", 128'(read_valid), 128'(0));
            end else begin
                mon_exp = exp_data.pop_front();
                check_output("beat_data", read_data, mon_exp);
            end
        end
        if (read_done) begin
            done_count++;
            check_output("done_after_last_beat", 128'(exp_data.size()), 128'(0));
        end
    end

    task automatic apply_stimulus(input logic [31:0] addr, input logic [10:0] cnt, input int stall, input bit gap);
        logic [31:0] a;
        int          rem;
        cmd_t        c;
        a   = addr & ~32'hF;
        rem = int'(cnt);
        for (int i = 0; i < int'(cnt); i++) exp_data.push_back(beat_data(a + (32'(i) << 4)));
        while (rem > 0) begin
            c.addr = a;
            c.bc   = 8'((rem > MAXB) ? MAXB : rem);
            exp_cmd.push_back(c);
            a   = a + (32'(c.bc) << 4);
            rem = rem - int'(c.bc);
        end
        stall_cfg  = stall;
        gap_en     = gap;
        read_addr  = addr;
        read_cnt   = cnt;
        read_start = 1'b1;
        @(posedge clk);
        #1;
        read_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (done_count != d0) ok = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic finish_checks(input string tag, input int c0, input int d0, input int budget, input int bursts);
        bit ok;
        wait_done(d0, budget, ok);
        check_output({tag, "_done_seen"}, 128'(ok), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        check_output({tag, "_beats_drained"}, 128'(exp_data.size()), 128'(0));
        check_output({tag, "_cmds_drained"}, 128'(exp_cmd.size()), 128'(0));
        check_output({tag, "_burst_count"}, 128'(cmd_count - c0), 128'(bursts));
        check_output({tag, "_done_once"}, 128'(done_count - d0), 128'(1));
        exp_data.delete();
        exp_cmd.delete();
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int c0, d0;
        c0 = cmd_count;
        d0 = done_count;
        apply_stimulus(v.addr, v.cnt, v.stall, v.gap);
        finish_checks(tag, c0, d0, int'(v.cnt) * 5 + 100, v.exp_bursts);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  c0, d0, r0;
        bit  found;
        vec_t post;

        vecs[0] = '{32'h2000_0000, 11'd4,    0, 1'b0, 1};
        vecs[1] = '{32'h2000_0000, 11'd130,  0, 1'b0, 3};
        vecs[2] = '{32'h2000_0000, 11'd8,    5, 1'b0, 1};
        vecs[3] = '{32'h1000_0007, 11'd64,   0, 1'b1, 1};
        vecs[4] = '{32'h2000_0000, 11'd65,   2, 1'b1, 2};
        vecs[5] = '{32'hFFFF_FFE0, 11'd5,    0, 1'b0, 1};
        vecs[6] = '{32'h0000_0100, 11'd2047, 0, 1'b0, 32};
        vecs[7] = '{32'h0000_0000, 11'd1,    1, 1'b0, 1};

        rst_n      = 1'b0;
        read_start = 1'b0;
        read_addr  = '0;
        read_cnt   = '0;
        slave_dv   = 1'b0;
        noise_dv   = 1'b0;
        slave_wr   = 1'b0;
        slave_rd   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_read", 128'(bus.read), 128'(0));
        check_output("rst_address", 128'(bus.address), 128'(0));
        check_output("rst_burstcount", 128'(bus.burstcount), 128'(0));
        check_output("rst_read_valid", 128'(read_valid), 128'(0));
        check_output("rst_read_data", read_data, 128'(0));
        check_output("rst_read_done", 128'(read_done), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

        // Zero-length request: done one cycle after the start, no bus activity.
        r0 = read_seen;
        d0 = done_count;
        read_cnt   = 11'd0;
        read_addr  = 32'h2000_0000;
        read_start = 1'b1;
        @(negedge clk);
        #1;
        check_output("zero_done_early", 128'(read_done), 128'(0));
        @(posedge clk);
        #1;
        read_start = 1'b0;
        @(negedge clk);
        #1;
        check_output("zero_done_pulse", 128'(read_done), 128'(1));
        @(negedge clk);
        #1;
        check_output("zero_done_clear", 128'(read_done), 128'(0));
        check_output("zero_no_read", 128'(read_seen - r0), 128'(0));
        check_output("zero_done_once", 128'(done_count - d0), 128'(1));
        @(posedge clk);
        #1;

        // Stray readdatavalid while idle must be ignored.
        #2;
        noise_dv = 1'b1;
        @(negedge clk);
        #1;
        check_output("idle_dv_ignored", 128'(read_valid), 128'(0));
        @(posedge clk);
        #1;
        noise_dv = 1'b0;
        post = '{32'h2000_0040, 11'd3, 0, 1'b0, 1};
        run_vector(post, "after_noise");

        // Second start mid-transfer is ignored.
        c0 = cmd_count;
        d0 = done_count;
        apply_stimulus(32'h2000_0000, 11'd100, 0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        read_addr  = 32'h3000_0000;
        read_cnt   = 11'd5;
        read_start = 1'b1;
        @(posedge clk);
        #1;
        read_start = 1'b0;
        finish_checks("restart_ignored", c0, d0, 600, 2);

        // Reset while beats are streaming aborts the transfer without done.
        apply_stimulus(32'h2000_0000, 11'd40, 0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (read_valid) found = 1'b1;
        end
        check_output("rst_mid_in_data", 128'(found), 128'(1));
        d0 = done_count;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_read", 128'(bus.read), 128'(0));
        check_output("rst_mid_read_valid", 128'(read_valid), 128'(0));
        check_output("rst_mid_read_done", 128'(read_done), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        exp_data.delete();
        exp_cmd.delete();
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_output("rst_mid_no_done", 128'(done_count - d0), 128'(0));
        post = '{32'h4000_0000, 11'd6, 1, 1'b0, 1};
        run_vector(post, "post_reset");

        $display("[TB] %0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
